// File: rtl/instr_mem_loadable_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_mem_loadable_if - fetch port and byte-load port bundle for         |
// | instr_mem_loadable. Revision: 1.0                                        |
// +--------------------------------------------------------------------------+
interface instr_mem_loadable_if #(
   parameter int ADDR_WIDTH  = 8,
   parameter int INSTR_WIDTH = 28
);
   logic [ADDR_WIDTH-1:0]  iAddress;
   logic                   iFetch;
   logic [INSTR_WIDTH-1:0] oInstruction;
   logic                   oInstrValid;
   logic                   iLoadStart;
   logic [ADDR_WIDTH-1:0]  iLoadBase;
   logic                   iByteValid;
   logic [7:0]             iByte;
   logic                   iLoadEnd;
   logic                   oBusy;
   logic                   oLoadDone;
   logic                   oLoadError;
   logic [ADDR_WIDTH:0]    oWordCount;

   modport master (
      output iAddress, iFetch, iLoadStart, iLoadBase, iByteValid, iByte, iLoadEnd,
      input  oInstruction, oInstrValid, oBusy, oLoadDone, oLoadError, oWordCount
   );

   modport slave (
      input  iAddress, iFetch, iLoadStart, iLoadBase, iByteValid, iByte, iLoadEnd,
      output oInstruction, oInstrValid, oBusy, oLoadDone, oLoadError, oWordCount
   );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loadable.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_mem_loadable - byte-loadable instruction memory with registered    |
// | fetch; optional load checksum via IMEM_CHECKSUM_EN. Revision: 1.0        |
// +--------------------------------------------------------------------------+
module instr_mem_loadable #(
   parameter int                     ADDR_WIDTH    = 8,
   parameter int                     INSTR_WIDTH   = 28,
   parameter logic [INSTR_WIDTH-1:0] DEFAULT_INSTR = '0
) (
   input  wire                  clk,
   input  wire                  rst_n,
   instr_mem_loadable_if.slave  bus
);
   localparam int c_DEPTH = 2 ** ADDR_WIDTH;
   localparam int c_BYTES = (INSTR_WIDTH + 7) / 8;
   localparam int c_SW    = 8 * c_BYTES;
   localparam int c_BCW   = $clog2(c_BYTES) + 1;
   localparam logic [c_BCW-1:0]    c_LAST      = c_BCW'(c_BYTES - 1);
   localparam logic [ADDR_WIDTH:0] c_COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   logic [INSTR_WIDTH-1:0] r_mem [c_DEPTH];
   logic [c_DEPTH-1:0]     r_flag;
   logic [ADDR_WIDTH-1:0]  r_ptr;
   logic [c_BCW-1:0]       r_bcnt;
   logic [c_SW-1:0]        r_shift;
   logic [ADDR_WIDTH:0]    r_count;
   logic [INSTR_WIDTH-1:0] r_instr;
   logic                   r_valid;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_err;

   logic [c_SW-1:0]        w_shift_next;
   logic [INSTR_WIDTH-1:0] w_word;
   logic                   w_byte_acc;
   logic                   w_word_we;
   logic                   w_end_err;

   // A restart or end in the same cycle takes precedence over a data byte.
   assign w_byte_acc   = (r_state == S_LOAD) && !bus.iLoadStart && !bus.iLoadEnd && bus.iByteValid;
   assign w_word_we    = w_byte_acc && (r_bcnt == c_LAST);
   assign w_shift_next = (r_shift << 8) | c_SW'(bus.iByte);
   assign w_word       = w_shift_next[INSTR_WIDTH-1:0];

`ifdef IMEM_CHECKSUM_EN
   logic [7:0] r_csum;
   assign w_end_err = (r_bcnt != '0) || (bus.iByte != r_csum);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_csum <= 8'h00;
      end else if (bus.iLoadStart && (r_state != S_DONE)) begin
         r_csum <= 8'h00;
      end else if (w_byte_acc) begin
         r_csum <= r_csum ^ bus.iByte;
      end
   end
`else
   assign w_end_err = (r_bcnt != '0);
`endif

   // Array contents are deliberately not reset; the flag vector masks them.
   always_ff @(posedge clk) begin
      if (rst_n && w_word_we) begin
         r_mem[r_ptr] <= w_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_flag  <= '0;
         r_ptr   <= '0;
         r_bcnt  <= '0;
         r_shift <= '0;
         r_count <= '0;
         r_instr <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;

         if (bus.iFetch && !r_busy) begin
            r_instr <= r_flag[bus.iAddress] ? r_mem[bus.iAddress] : DEFAULT_INSTR;
            r_valid <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (bus.iLoadStart) begin
                  r_state <= S_LOAD;
                  r_busy  <= 1'b1;
                  r_ptr   <= bus.iLoadBase;
                  r_bcnt  <= '0;
                  r_count <= '0;
                  r_err   <= 1'b0;
               end
            end
            S_LOAD: begin
               if (bus.iLoadStart) begin
                  r_ptr   <= bus.iLoadBase;
                  r_bcnt  <= '0;
                  r_count <= '0;
                  r_err   <= 1'b0;
               end else if (bus.iLoadEnd) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_bcnt  <= '0;
                  r_err   <= w_end_err;
               end else if (w_byte_acc) begin
                  r_shift <= w_shift_next;
                  if (w_word_we) begin
                     r_bcnt        <= '0;
                     r_flag[r_ptr] <= 1'b1;
                     r_ptr         <= r_ptr + ADDR_WIDTH'(1);
                     if (r_count != c_COUNT_MAX) begin
                        r_count <= r_count + (ADDR_WIDTH + 1)'(1);
                     end
                  end else begin
                     r_bcnt <= r_bcnt + c_BCW'(1);
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.oInstruction = r_instr;
   assign bus.oInstrValid  = r_valid;
   assign bus.oBusy        = r_busy;
   assign bus.oLoadDone    = r_done;
   assign bus.oLoadError   = r_err;
   assign bus.oWordCount   = r_count;
endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loadable.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_mem_loadable - scoreboard bench for instr_mem_loadable          |
// | (checksum cases follow IMEM_CHECKSUM_EN). Revision: 1.0                  |
// +--------------------------------------------------------------------------+
module tb_instr_mem_loadable;
   localparam int             AW  = 8;
   localparam int             IW  = 28;
   localparam logic [IW-1:0]  DEF = 28'h5A5A5A5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [IW-1:0] q_exp [$];
   logic [IW-1:0] q_obs [$];

   always #5 clk = ~clk;

   instr_mem_loadable_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

   instr_mem_loadable #(
      .ADDR_WIDTH   (AW),
      .INSTR_WIDTH  (IW),
      .DEFAULT_INSTR(DEF)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Every valid fetch result lands in the observed queue.
   always @(negedge clk) begin
      if (rst_n && bus.oInstrValid) q_obs.push_back(bus.oInstruction);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic load_start(input logic [AW-1:0] base);
      bus.iLoadStart = 1'b1;
      bus.iLoadBase  = base;
      tick();
      bus.iLoadStart = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.iByteValid = 1'b1;
      bus.iByte      = b;
      tick();
      bus.iByteValid = 1'b0;
   endtask

   task automatic send_word(input logic [IW-1:0] w);
      logic [31:0] v;
      v = {4'h0, w};
      for (int i = 3; i >= 0; i--) send_byte(v[8*i +: 8]);
   endtask

   task automatic load_end(input logic [7:0] cs);
      bus.iLoadEnd = 1'b1;
      bus.iByte    = cs;
      tick();
      bus.iLoadEnd = 1'b0;
   endtask

   task automatic fetch(input logic [AW-1:0] a, input logic [IW-1:0] exp);
      bus.iFetch   = 1'b1;
      bus.iAddress = a;
      q_exp.push_back(exp);
      tick();
      bus.iFetch = 1'b0;
   endtask

   task automatic test_reset();
      bus.iFetch = 0; bus.iAddress = '0; bus.iLoadStart = 0; bus.iLoadBase = '0;
      bus.iByteValid = 0; bus.iByte = '0; bus.iLoadEnd = 0;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      settle();
      n_checks++;
      if ({bus.oInstruction, bus.oInstrValid, bus.oBusy, bus.oLoadDone, bus.oLoadError, bus.oWordCount} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got instr=%h v=%b busy=%b done=%b err=%b cnt=%0d required all zero",
                  bus.oInstruction, bus.oInstrValid, bus.oBusy, bus.oLoadDone, bus.oLoadError, bus.oWordCount);
      end
      fetch(8'h05, DEF);
      settle();
      n_checks++;
      if (q_obs.size() != q_exp.size()) begin
         n_fail++;
         $display("FAIL unwritten_count: got %0d results required %0d", q_obs.size(), q_exp.size());
      end
      while (q_obs.size() > 0 && q_exp.size() > 0) begin
         logic [IW-1:0] o, e;
         o = q_obs.pop_front(); e = q_exp.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL unwritten_data: got %h required %h", o, e); end
      end
      q_obs.delete(); q_exp.delete();
   endtask

   task automatic test_basic_load();
      load_start(8'h10);
      n_checks++;
      if (bus.oBusy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", bus.oBusy); end
      send_word(28'h1234567);
      send_word(28'hABCDEF0);
      load_end(8'h00);
      n_checks++;
      if (bus.oLoadDone !== 1'b1 || bus.oWordCount !== 9'd2 || bus.oLoadError !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done: got done=%b cnt=%0d err=%b required done=1 cnt=2 err=0",
                  bus.oLoadDone, bus.oWordCount, bus.oLoadError);
      end
      fetch(8'h10, 28'h1234567);
      n_checks++;
      if (bus.oLoadDone !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b required 0", bus.oLoadDone); end
      fetch(8'h11, 28'hABCDEF0);
      fetch(8'h12, DEF);
      settle();
      n_checks++;
      if (q_obs.size() != q_exp.size()) begin
         n_fail++;
         $display("FAIL basic_count: got %0d results required %0d", q_obs.size(), q_exp.size());
      end
      while (q_obs.size() > 0 && q_exp.size() > 0) begin
         logic [IW-1:0] o, e;
         o = q_obs.pop_front(); e = q_exp.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL basic_data: got %h required %h", o, e); end
      end
      q_obs.delete(); q_exp.delete();
   endtask

   task automatic test_wrap();
      load_start(8'hFF);
      send_word(28'h1111111);
      send_word(28'h2222222);
      load_end(8'h00);
      n_checks++;
      if (bus.oWordCount !== 9'd2) begin n_fail++; $display("FAIL wrap_cnt: got %0d required 2", bus.oWordCount); end
      fetch(8'hFF, 28'h1111111);
      fetch(8'h00, 28'h2222222);
      fetch(8'h01, DEF);
      settle();
      n_checks++;
      if (q_obs.size() != q_exp.size()) begin
         n_fail++;
         $display("FAIL wrap_count: got %0d results required %0d", q_obs.size(), q_exp.size());
      end
      while (q_obs.size() > 0 && q_exp.size() > 0) begin
         logic [IW-1:0] o, e;
         o = q_obs.pop_front(); e = q_exp.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL wrap_data: got %h required %h", o, e); end
      end
      q_obs.delete(); q_exp.delete();
   endtask

   task automatic test_partial_restart();
      load_start(8'h40);
      send_byte(8'h0A); send_byte(8'hBB); send_byte(8'hCC);
      load_end(8'h00);
      n_checks++;
      if (bus.oLoadError !== 1'b1 || bus.oWordCount !== 9'd0) begin
         n_fail++;
         $display("FAIL partial_err: got err=%b cnt=%0d required err=1 cnt=0", bus.oLoadError, bus.oWordCount);
      end
      tick();
      // Restart mid-word: the two bytes aimed at 0x50 must vanish.
      load_start(8'h50);
      n_checks++;
      if (bus.oLoadError !== 1'b0) begin n_fail++; $display("FAIL restart_err_clear: got %b required 0", bus.oLoadError); end
      send_byte(8'h07); send_byte(8'h77);
      load_start(8'h60);
      send_word(28'h9876543);
      load_end(8'h00);
      n_checks++;
      if (bus.oLoadError !== 1'b0 || bus.oWordCount !== 9'd1) begin
         n_fail++;
         $display("FAIL restart_done: got err=%b cnt=%0d required err=0 cnt=1", bus.oLoadError, bus.oWordCount);
      end
      fetch(8'h40, DEF);
      fetch(8'h50, DEF);
      fetch(8'h60, 28'h9876543);
      fetch(8'h61, DEF);
      settle();
      n_checks++;
      if (q_obs.size() != q_exp.size()) begin
         n_fail++;
         $display("FAIL partial_count: got %0d results required %0d", q_obs.size(), q_exp.size());
      end
      while (q_obs.size() > 0 && q_exp.size() > 0) begin
         logic [IW-1:0] o, e;
         o = q_obs.pop_front(); e = q_exp.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL partial_data: got %h required %h", o, e); end
      end
      q_obs.delete(); q_exp.delete();
   endtask

   task automatic test_busy_fetch();
      load_start(8'h20);
      bus.iFetch = 1'b1; bus.iAddress = 8'h10;
      send_byte(8'h03);
      n_checks++;
      if (bus.oInstrValid !== 1'b0) begin n_fail++; $display("FAIL busy_drop: got valid=%b required 0", bus.oInstrValid); end
      send_byte(8'h14);
      bus.iFetch = 1'b0;
      send_byte(8'h15); send_byte(8'h16);
      load_end(8'h00);
      n_checks++;
      if (bus.oBusy !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b required 0", bus.oBusy); end
      fetch(8'h20, 28'h3141516);
      n_checks++;
      if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== 28'h3141516) begin
         n_fail++;
         $display("FAIL busy_after: got valid=%b data=%h required valid=1 data=3141516",
                  bus.oInstrValid, bus.oInstruction);
      end
      settle();
      n_checks++;
      if (q_obs.size() != q_exp.size()) begin
         n_fail++;
         $display("FAIL busy_count: got %0d results required %0d", q_obs.size(), q_exp.size());
      end
      while (q_obs.size() > 0 && q_exp.size() > 0) begin
         logic [IW-1:0] o, e;
         o = q_obs.pop_front(); e = q_exp.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL busy_data: got %h required %h", o, e); end
      end
      q_obs.delete(); q_exp.delete();
   endtask

   task automatic test_checksum();
      logic e_bad;
`ifdef IMEM_CHECKSUM_EN
      e_bad = 1'b1;
`else
      e_bad = 1'b0;
`endif
      load_start(8'h30);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
      load_end(8'h0F);
      n_checks++;
      if (bus.oLoadError !== 1'b0) begin n_fail++; $display("FAIL csum_good: got err=%b required 0", bus.oLoadError); end
      tick();
      load_start(8'h31);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
      load_end(8'h0E);
      n_checks++;
      if (bus.oLoadError !== e_bad) begin
         n_fail++;
         $display("FAIL csum_bad: got err=%b required %b", bus.oLoadError, e_bad);
      end
      fetch(8'h30, 28'h1020408);
      fetch(8'h31, 28'h1020408);
      settle();
      n_checks++;
      if (q_obs.size() != q_exp.size()) begin
         n_fail++;
         $display("FAIL csum_count: got %0d results required %0d", q_obs.size(), q_exp.size());
      end
      while (q_obs.size() > 0 && q_exp.size() > 0) begin
         logic [IW-1:0] o, e;
         o = q_obs.pop_front(); e = q_exp.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL csum_data: got %h required %h", o, e); end
      end
      q_obs.delete(); q_exp.delete();
   endtask

   task automatic test_saturate();
      // 257 words from 0x80: the last one overwrites 0x80, the count pins at depth.
      load_start(8'h80);
      for (int i = 0; i <= 256; i++) send_word(28'h0C00000 + 28'(i));
      load_end(8'h00);
      n_checks++;
      if (bus.oWordCount !== 9'd256) begin n_fail++; $display("FAIL sat_cnt: got %0d required 256", bus.oWordCount); end
      fetch(8'h80, 28'h0C00100);
      fetch(8'h81, 28'h0C00001);
      fetch(8'h7F, 28'h0C000FF);
      settle();
      n_checks++;
      if (q_obs.size() != q_exp.size()) begin
         n_fail++;
         $display("FAIL sat_count: got %0d results required %0d", q_obs.size(), q_exp.size());
      end
      while (q_obs.size() > 0 && q_exp.size() > 0) begin
         logic [IW-1:0] o, e;
         o = q_obs.pop_front(); e = q_exp.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL sat_data: got %h required %h", o, e); end
      end
      q_obs.delete(); q_exp.delete();
   endtask

   task automatic test_reset_midload();
      load_start(8'h90);
      send_word(28'h7654321);
      send_byte(8'h01);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_checks++;
      if (bus.oBusy !== 1'b0 || bus.oWordCount !== 9'd0) begin
         n_fail++;
         $display("FAIL midreset_state: got busy=%b cnt=%0d required busy=0 cnt=0", bus.oBusy, bus.oWordCount);
      end
      fetch(8'h90, DEF);
      fetch(8'h10, DEF);
      settle();
      n_checks++;
      if (q_obs.size() != q_exp.size()) begin
         n_fail++;
         $display("FAIL midreset_count: got %0d results required %0d", q_obs.size(), q_exp.size());
      end
      while (q_obs.size() > 0 && q_exp.size() > 0) begin
         logic [IW-1:0] o, e;
         o = q_obs.pop_front(); e = q_exp.pop_front();
         n_checks++;
         if (o !== e) begin n_fail++; $display("FAIL midreset_data: got %h required %h", o, e); end
      end
      q_obs.delete(); q_exp.delete();
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_wrap();
      test_partial_restart();
      test_busy_fetch();
      test_checksum();
      test_saturate();
      test_reset_midload();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
